// File: rtl/soc_system_spi_slave_pkg.sv
// ============================================================================
// soc_system_spi_slave_pkg : register map, status/control bit positions
// Rev 1.0
// ============================================================================
`default_nettype none

package soc_system_spi_slave_pkg;

   localparam int DATABITS_DEF = 8;

   localparam logic [2:0] ADDR_RXDATA  = 3'd0;
   localparam logic [2:0] ADDR_TXDATA  = 3'd1;
   localparam logic [2:0] ADDR_STATUS  = 3'd2;
   localparam logic [2:0] ADDR_CONTROL = 3'd3;

   localparam int BIT_ROE  = 3;
   localparam int BIT_TOE  = 4;
   localparam int BIT_TMT  = 5;
   localparam int BIT_TRDY = 6;
   localparam int BIT_RRDY = 7;
   localparam int BIT_E    = 8;
   localparam int BIT_TUR  = 9;

   // Bits that carry an interrupt enable in the control register
   localparam logic [15:0] CTRL_MASK = 16'h03D8;

   typedef struct packed {
      logic tur;
      logic rrdy;
      logic trdy;
      logic tmt;
      logic toe;
      logic roe;
   } status_t;

   function automatic logic [15:0] pack_status(input status_t s);
      logic [15:0] w;
      w           = '0;
      w[BIT_ROE]  = s.roe;
      w[BIT_TOE]  = s.toe;
      w[BIT_TMT]  = s.tmt;
      w[BIT_TRDY] = s.trdy;
      w[BIT_RRDY] = s.rrdy;
      w[BIT_E]    = s.roe | s.toe | s.tur;
      w[BIT_TUR]  = s.tur;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_slave_sync.sv
// ============================================================================
// spi_slave_sync : multi-flop synchroniser plus one delayed copy for edge detect
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_slave_sync #(
   parameter int               WIDTH     = 3,
   parameter int               STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] prev_o
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STAGES; i++) stage_q[i] <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         stage_q[0] <= async_i;
         for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
         prev_q <= stage_q[STAGES-1];
      end
   end

   assign sync_o = stage_q[STAGES-1];
   assign prev_o = prev_q;

endmodule

`default_nettype wire

// File: rtl/soc_system_spi_slave.sv
// ============================================================================
// soc_system_spi_slave : mode-3 SPI target with memory-mapped rx/tx/status/ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module soc_system_spi_slave
   import soc_system_spi_slave_pkg::*;
#(
   parameter int DATABITS    = DATABITS_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spi_select,
   input  logic [2:0]  mem_addr,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [15:0] data_from_cpu,
   output logic [15:0] data_to_cpu,
   output logic        irq,
   input  logic        SCLK,
   input  logic        SS_n,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISO_oe
);

   localparam int                CNT_W    = (DATABITS > 1) ? $clog2(DATABITS) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATABITS - 1);

   logic [2:0] pins_sync, pins_prev;
   logic       unused_mosi_prev;

   spi_slave_sync #(
      .WIDTH     (3),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (3'b111)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i ({SCLK, SS_n, MOSI}),
      .sync_o  (pins_sync),
      .prev_o  (pins_prev)
   );

   assign unused_mosi_prev = pins_prev[0];

   logic [DATABITS-1:0] rx_shift_q, rx_shift_d;
   logic [DATABITS-1:0] rx_holding_q, rx_holding_d;
   logic [DATABITS-1:0] tx_holding_q, tx_holding_d;
   logic [DATABITS-1:0] tx_shift_q, tx_shift_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                frame_active_q, frame_active_d;
   logic                tx_primed_q, tx_primed_d;
   logic                roe_q, roe_d, toe_q, toe_d, tur_q, tur_d, rrdy_q, rrdy_d;
   logic [15:0]         ctrl_q, ctrl_d;
   logic [15:0]         data_to_cpu_q, data_to_cpu_d;
   logic                irq_q, irq_d;

   logic ss_s, ss_fall, ss_rise, in_frame, sclk_rise, sclk_fall, frame_done, load_tx;
   logic wr, rd, wr_tx, wr_status, wr_ctrl, rd_rx;
   logic [15:0] status_word;
   status_t     st;

   assign ss_s       = pins_sync[1];
   assign ss_fall    =  pins_prev[1] & ~ss_s;
   assign ss_rise    = ~pins_prev[1] &  ss_s;
   assign in_frame   = frame_active_q & ~ss_s;
   assign sclk_rise  = in_frame & ~pins_prev[2] &  pins_sync[2];
   assign sclk_fall  = in_frame &  pins_prev[2] & ~pins_sync[2];
   assign frame_done = sclk_rise & (bit_cnt_q == LAST_BIT);
   assign load_tx    = ss_fall | frame_done;

   assign wr        = spi_select & ~write_n;
   assign rd        = spi_select & ~read_n;
   assign wr_tx     = wr & (mem_addr == ADDR_TXDATA);
   assign wr_status = wr & (mem_addr == ADDR_STATUS);
   assign wr_ctrl   = wr & (mem_addr == ADDR_CONTROL);
   assign rd_rx     = rd & (mem_addr == ADDR_RXDATA);

   always_comb begin
      st.tur  = tur_q;
      st.rrdy = rrdy_q;
      st.trdy = ~tx_primed_q;
      st.tmt  = ~tx_primed_q & ~frame_active_q;
      st.toe  = toe_q;
      st.roe  = roe_q;
      status_word = pack_status(st);
   end

   always_comb begin
      rx_shift_d     = rx_shift_q;
      rx_holding_d   = rx_holding_q;
      tx_holding_d   = tx_holding_q;
      tx_shift_d     = tx_shift_q;
      bit_cnt_d      = bit_cnt_q;
      frame_active_d = frame_active_q;
      tx_primed_d    = tx_primed_q;
      roe_d          = roe_q;
      toe_d          = toe_q;
      tur_d          = tur_q;
      rrdy_d         = rrdy_q;
      ctrl_d         = ctrl_q;
      data_to_cpu_d  = data_to_cpu_q;

      // Clears come first so that any error set in the same cycle wins
      if (wr_status) begin
         roe_d = 1'b0;
         toe_d = 1'b0;
         tur_d = 1'b0;
      end
      if (rd_rx) rrdy_d = 1'b0;

      if (ss_fall) begin
         bit_cnt_d      = '0;
         frame_active_d = 1'b1;
         rx_shift_d     = '0;
      end else if (ss_rise) begin
         bit_cnt_d      = '0;
         frame_active_d = 1'b0;
      end else if (sclk_rise) begin
         rx_shift_d = {rx_shift_q[DATABITS-2:0], pins_sync[0]};
         if (frame_done) begin
            bit_cnt_d    = '0;
            rx_holding_d = rx_shift_d;
            rrdy_d       = 1'b1;
            if (rrdy_q && !rd_rx) roe_d = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end else if (sclk_fall && bit_cnt_q != '0) begin
         tx_shift_d = {tx_shift_q[DATABITS-2:0], 1'b0};
      end

      // Load and a same-cycle tx write both see the old primed state
      if (load_tx) begin
         if (tx_primed_q) begin
            tx_shift_d  = tx_holding_q;
            tx_primed_d = 1'b0;
         end else begin
            tx_shift_d = '0;
            tur_d      = 1'b1;
         end
      end
      if (wr_tx) begin
         if (!tx_primed_q) begin
            tx_holding_d = data_from_cpu[DATABITS-1:0];
            tx_primed_d  = 1'b1;
         end else begin
            toe_d = 1'b1;
         end
      end

      if (wr_ctrl) ctrl_d = data_from_cpu & CTRL_MASK;

      if (rd) begin
         case (mem_addr)
            ADDR_RXDATA:  data_to_cpu_d = 16'(rx_holding_q);
            ADDR_STATUS:  data_to_cpu_d = status_word;
            ADDR_CONTROL: data_to_cpu_d = ctrl_q;
            default:      data_to_cpu_d = '0;
         endcase
      end

      irq_d = |(status_word & ctrl_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_shift_q     <= '0;
         rx_holding_q   <= '0;
         tx_holding_q   <= '0;
         tx_shift_q     <= '0;
         bit_cnt_q      <= '0;
         frame_active_q <= 1'b0;
         tx_primed_q    <= 1'b0;
         roe_q          <= 1'b0;
         toe_q          <= 1'b0;
         tur_q          <= 1'b0;
         rrdy_q         <= 1'b0;
         ctrl_q         <= '0;
         data_to_cpu_q  <= '0;
         irq_q          <= 1'b0;
      end else begin
         rx_shift_q     <= rx_shift_d;
         rx_holding_q   <= rx_holding_d;
         tx_holding_q   <= tx_holding_d;
         tx_shift_q     <= tx_shift_d;
         bit_cnt_q      <= bit_cnt_d;
         frame_active_q <= frame_active_d;
         tx_primed_q    <= tx_primed_d;
         roe_q          <= roe_d;
         toe_q          <= toe_d;
         tur_q          <= tur_d;
         rrdy_q         <= rrdy_d;
         ctrl_q         <= ctrl_d;
         data_to_cpu_q  <= data_to_cpu_d;
         irq_q          <= irq_d;
      end
   end

   assign data_to_cpu = data_to_cpu_q;
   assign irq         = irq_q;
   assign MISO        = ss_s ? 1'b1 : tx_shift_q[DATABITS-1];
   assign MISO_oe     = ~ss_s;

endmodule

`default_nettype wire

// File: tb/tb_soc_system_spi_slave.sv
// ============================================================================
// tb_soc_system_spi_slave : directed mode-3 master transfers against the slave
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_soc_system_spi_slave;

   localparam time HALF = 80ns;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        spi_select = 1'b0;
   logic [2:0]  mem_addr = 3'd0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [15:0] data_from_cpu = 16'h0000;
   logic [15:0] data_to_cpu;
   logic        irq;
   logic        SCLK = 1'b1;
   logic        SS_n = 1'b1;
   logic        MOSI = 1'b1;
   logic        MISO;
   logic        MISO_oe;

   int checks = 0;
   int errors = 0;

   soc_system_spi_slave dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .spi_select    (spi_select),
      .mem_addr      (mem_addr),
      .read_n        (read_n),
      .write_n       (write_n),
      .data_from_cpu (data_from_cpu),
      .data_to_cpu   (data_to_cpu),
      .irq           (irq),
      .SCLK          (SCLK),
      .SS_n          (SS_n),
      .MOSI          (MOSI),
      .MISO          (MISO),
      .MISO_oe       (MISO_oe)
   );

   always #5ns clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1ns;
   endtask

   task automatic reg_write(input logic [2:0] addr, input logic [15:0] d);
      @(negedge clk);
      spi_select = 1'b1; write_n = 1'b0; mem_addr = addr; data_from_cpu = d;
      @(posedge clk);
      #1ns;
      spi_select = 1'b0; write_n = 1'b1;
   endtask

   task automatic reg_read(input logic [2:0] addr, output logic [15:0] d);
      @(negedge clk);
      spi_select = 1'b1; read_n = 1'b0; mem_addr = addr;
      @(posedge clk);
      #1ns;
      d = data_to_cpu;
      spi_select = 1'b0; read_n = 1'b1;
   endtask

   // Mode 3 master: drive on SCLK fall, sample MISO on SCLK rise
   task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx, output logic oe);
      rx = 8'h00;
      oe = 1'b0;
      SS_n = 1'b0;
      #HALF;
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = tx[7-i];
         #HALF;
         SCLK = 1'b1;
         rx = {rx[6:0], MISO};
         if (i == 0) oe = MISO_oe;
         #HALF;
      end
      SS_n = 1'b1;
      MOSI = 1'b1;
      #HALF;
      tick(10);
   endtask

   initial begin
      logic [15:0] d;
      logic [7:0]  mrx;
      logic        oe;

      // Reset values
      tick(3);
      check("rst_data", data_to_cpu, 16'h0000);
      check("rst_irq", {15'd0, irq}, 16'h0000);
      check("rst_miso", {15'd0, MISO}, 16'h0001);
      check("rst_oe", {15'd0, MISO_oe}, 16'h0000);
      reset_n = 1'b1;
      tick(3);
      reg_read(3'd2, d); check("rst_status", d, 16'h0060);
      reg_read(3'd3, d); check("rst_ctrl", d, 16'h0000);

      // Control readback masks unused bits
      reg_write(3'd3, 16'hFFFF);
      reg_read(3'd3, d); check("ctrl_mask", d, 16'h03D8);

      // Basic exchange: slave A5, master 3C
      reg_write(3'd1, 16'h00A5);
      reg_read(3'd2, d); check("primed_status", d, 16'h0000);
      spi_xfer(8'h3C, 8, mrx, oe);
      check("xfer1_miso", {8'h00, mrx}, 16'h00A5);
      check("xfer1_oe", {15'd0, oe}, 16'h0001);
      reg_read(3'd2, d); check("xfer1_status", d, 16'h03E0);
      reg_read(3'd0, d); check("xfer1_rx", d, 16'h003C);
      reg_read(3'd2, d); check("rrdy_cleared", d, 16'h0360);
      reg_write(3'd2, 16'h0000);
      reg_read(3'd2, d); check("status_clear", d, 16'h0060);

      // Overrun: two frames, no read in between, ROE irq enabled
      reg_write(3'd3, 16'h0008);
      spi_xfer(8'h11, 8, mrx, oe);
      check("ovr_irq_before", {15'd0, irq}, 16'h0000);
      spi_xfer(8'h22, 8, mrx, oe);
      reg_read(3'd2, d); check("ovr_status", d, 16'h03E8);
      check("ovr_irq", {15'd0, irq}, 16'h0001);
      reg_read(3'd0, d); check("ovr_rx", d, 16'h0022);
      reg_write(3'd2, 16'h0000);
      tick(2);
      check("ovr_irq_clr", {15'd0, irq}, 16'h0000);
      reg_read(3'd2, d); check("ovr_status_clr", d, 16'h0060);

      // Underrun: nothing primed
      spi_xfer(8'h5A, 8, mrx, oe);
      check("tur_miso", {8'h00, mrx}, 16'h0000);
      reg_read(3'd2, d); check("tur_status", d, 16'h03E0);
      reg_read(3'd0, d); check("tur_rx", d, 16'h005A);
      reg_write(3'd2, 16'h0000);

      // Tx overrun: second write dropped
      reg_write(3'd1, 16'h0055);
      reg_write(3'd1, 16'h0066);
      reg_read(3'd2, d); check("toe_status", d, 16'h0110);
      spi_xfer(8'h99, 8, mrx, oe);
      check("toe_miso", {8'h00, mrx}, 16'h0055);
      reg_read(3'd2, d); check("toe_status2", d, 16'h03F0);
      reg_read(3'd0, d); check("toe_rx", d, 16'h0099);
      reg_write(3'd2, 16'h0000);

      // Aborted frame after 4 bits, then a full frame
      spi_xfer(8'hF0, 4, mrx, oe);
      reg_read(3'd2, d); check("abort_status", d, 16'h0360);
      reg_write(3'd2, 16'h0000);
      spi_xfer(8'hC3, 8, mrx, oe);
      reg_read(3'd0, d); check("after_abort_rx", d, 16'h00C3);
      reg_write(3'd2, 16'h0000);

      // Reset mid-frame with TUR irq active
      reg_write(3'd3, 16'h0200);
      SS_n = 1'b0;
      tick(6);
      check("mid_oe", {15'd0, MISO_oe}, 16'h0001);
      check("mid_miso", {15'd0, MISO}, 16'h0000);
      check("mid_irq", {15'd0, irq}, 16'h0001);
      SCLK = 1'b0;
      tick(10);
      reg_read(3'd2, d); check("mid_status", d, 16'h0340);
      @(negedge clk);
      reset_n = 1'b0;
      #1ns;
      check("mrst_data", data_to_cpu, 16'h0000);
      check("mrst_irq", {15'd0, irq}, 16'h0000);
      check("mrst_miso", {15'd0, MISO}, 16'h0001);
      check("mrst_oe", {15'd0, MISO_oe}, 16'h0000);
      SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b1;
      tick(4);
      reset_n = 1'b1;
      tick(5);
      reg_read(3'd2, d); check("mrst_status", d, 16'h0060);
      reg_read(3'd3, d); check("mrst_ctrl", d, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/soc_system_spi_slave.md
# soc_system_spi_slave

SPI slave peripheral: the target-side counterpart to the HPS-facing SPI master, used to let an external SPI master (or a second FPGA/MCU) exchange bytes with the CPU. It synchronises SCLK/SS_n/MOSI into the system clock domain, shifts 8-bit MSB-first frames in SPI mode 3 (CPOL=1, CPHA=1), and exposes rx/tx holding registers, status, control and IRQ on the same memory-mapped register style as the master.

## Interface
Parameters:
- DATABITS, 8, frame width (only 8 is required).
- SYNC_STAGES, 2, synchroniser depth on SCLK/SS_n/MOSI.

Ports:
- clk  in  1  system clock; SCLK must not exceed clk/8.
- reset_n  in  1  asynchronous, active-low reset.
- spi_select  in  1  register-port chip select.
- mem_addr  in  3  register address.
- read_n / write_n  in  1  active-low read/write strobes.
- data_from_cpu  in  16  write data.
- data_to_cpu  out  16  registered read data.
- irq  out  1  registered interrupt.
- SCLK, SS_n, MOSI  in  1  SPI pins (asynchronous).
- MISO  out  1  serial data out; MISO_oe  out  1  high while selected.

## Operation
- Register map: 0 rx data (r), 1 tx data (w), 2 status (r; any write clears ROE/TOE/TUR), 3 control (r/w).
- Status bits: 3 ROE, 4 TOE, 5 TMT, 6 TRDY, 7 RRDY, 8 E = ROE|TOE|TUR, 9 TUR; others 0.
- Control bits: interrupt enables at the same positions 3,4,6,7,8,9; read back as written, other bits 0.
- irq <= OR of (status bit & enable) over those positions, one clk late.
- TRDY = ~tx_primed; TMT = ~tx_primed & ~frame_active.
- Write addr 1: if TRDY, tx_holding <= data[7:0], tx_primed <= 1; else TOE <= 1, data dropped.
- Read addr 0 clears RRDY.
- Synchronised SS_n fall: bit_cnt <= 0, frame_active <= 1, tx_shift loaded (below).
- Load rule: tx_primed ? tx_holding (tx_primed <= 0) : 8'h00 and TUR <= 1.
- SCLK rising edge (synchronised): rx_shift <= {rx_shift[6:0], MOSI}; bit_cnt++.
- On 8th rise: rx_holding <= assembled byte; RRDY <= 1; ROE <= 1 if RRDY already set (old byte overwritten); bit_cnt <= 0; tx_shift reloaded by load rule.
- SCLK falling edge: shift tx_shift left unless bit_cnt == 0 (first fall of a frame, MSB already presented).
- MISO = tx_shift[7] while selected, 1 otherwise; MISO_oe = ~SS_n(synced).
- SS_n rise mid-byte: partial rx discarded, no RRDY; loaded tx byte counts as consumed; frame_active <= 0.
- Simultaneous events: CPU rx read and frame completion in same cycle -> RRDY stays 1, no ROE. CPU tx write and load in same cycle -> write goes to holding, load sees old primed state. Status write and error set same cycle -> set wins.

## Timing
- Reset: data_to_cpu 0, irq 0, MISO 1, MISO_oe 0, all status/control 0 (TRDY/TMT read 1), tx_shift 0, bit_cnt 0.
- Pin-to-edge latency: SYNC_STAGES+1 clk (3 at default).
- MISO update: ≤ 4 clk after SCLK fall, so valid well before next rise at clk ≥ 8×SCLK.
- Register write takes effect on the clk edge where spi_select & ~write_n; read data valid the clk after address presented; RRDY clear on the read-cycle edge.
- RRDY rises 1 clk after the synchronised 8th rising edge.

## Structure
- Package soc_system_spi_slave_pkg: register address constants, status/control bit indices, DATABITS default.
- One sub-module: spi_slave_sync (parameterised-width multi-flop synchroniser with registered previous value for edge detect), instantiated once for {SCLK, SS_n, MOSI}.

## Test plan
- Tx 8'hA5 written, master clocks 8'h3C in mode 3 -> master receives A5, rx reads 3C, RRDY=1 then 0 after read, TMT=1.
- Two frames without rx read (11, 22) -> rx reads 22, ROE=1, irq asserts if bit 3 enabled; status write clears ROE.
- Frame with no tx primed -> MISO sends 00, TUR=1, E=1.
- Two tx writes before frame (55, 66) -> second sets TOE, master receives 55.
- SS_n deasserted after 4 bits -> RRDY stays 0, next full frame 8'hC3 received correctly.
- Reset asserted mid-frame -> all outputs to reset values within one clk, MISO_oe 0.
